ap_err_eval_8b: RTL

- Self-contained error-evaluation harness for the 8-bit approximate unsigned multipliers.
- Sweeps all 2^(2*DW) operand pairs through one multiplier instance, which sits outside this block.
  - The operands drive the multiplier's muld/mulr.
  - The multiplier's 16-bit res returns to this block combinationally in the same cycle.
- Compares each res against the exact product and accumulates error count, sum of absolute errors and maximum absolute error.
- Used to score candidate approximate multipliers in hardware.

---
 rtl/ap_eval_pkg.sv | 19 +
 rtl/ap_err_eval_acc.sv | 44 ++++
 rtl/ap_err_eval_8b.sv | 102 ++++++++++
 3 files changed

// File: rtl/ap_eval_pkg.sv
// rtl/ap_eval_pkg.sv - shared state encoding and sizing for the approximate multiplier error harness
package ap_eval_pkg;

  // default operand width and the sweep geometry it implies
  localparam int DW_DEF    = 8;
  localparam int PW        = 2 * DW_DEF;
  localparam int SWEEP_LEN = 1 << PW;

  // cycles spent after the last pair so it clears stages E and A
  localparam int DRAIN_CYC = 2;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ap_err_eval_acc.sv
// rtl/ap_err_eval_acc.sv - stage A: absolute error and error statistics accumulation
module ap_err_eval_acc #(
  parameter int PW    = 16,
  parameter int SUM_W = 32,
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             v_e,
  input  logic [PW-1:0]    approx,
  input  logic [PW-1:0]    exact,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [PW-1:0]    max_ed
);

  logic [PW-1:0] ed;

  // magnitude of the error; compare first so the subtract never wraps
  always_comb begin
    ed = '0;
    if (approx >= exact) ed = approx - exact;
    else                 ed = exact - approx;
  end

  // accumulate statistics for each valid captured pair; clear on sweep start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else if (clr) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else if (v_e) begin
      err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, (ed != '0)};
      sum_ed  <= sum_ed + {{(SUM_W-PW){1'b0}}, ed};
      if (ed > max_ed) max_ed <= ed;
    end
  end

endmodule

// File: rtl/ap_err_eval_8b.sv
// rtl/ap_err_eval_8b.sv - exhaustive operand sweep and error scoring of an external approximate multiplier
module ap_err_eval_8b
  import ap_eval_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int SUM_W = 32,
  parameter int CNT_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DW-1:0]     muld_o,
  output logic [DW-1:0]     mulr_o,
  input  logic [2*DW-1:0]   res_i,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [2*DW-1:0]   max_ed
);

  localparam int PWD = 2 * DW;

  state_t         state, state_nx;
  logic           load;
  logic [PWD-1:0] idx;
  logic [1:0]     dcnt;
  logic           v_e;
  logic [PWD-1:0] approx_e;
  logic [PWD-1:0] exact_e;

  assign muld_o = idx[DW-1:0];
  assign mulr_o = idx[PWD-1:DW];
  assign busy   = (state == SWEEP) || (state == DRAIN);
  assign done   = (state == DONE);

  // next-state decode; start is honoured only while idle or finished
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SWEEP;
        end
      end
      SWEEP:   if (idx == {PWD{1'b1}}) state_nx = DRAIN;
      DRAIN:   if (dcnt == 2'(DRAIN_CYC - 1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // operand index advances each sweep cycle and holds on the last pair; drain cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      dcnt <= '0;
    end else begin
      if (load)                                     idx <= '0;
      else if (state == SWEEP && state_nx == SWEEP) idx <= idx + 1'b1;
      if (state == DRAIN) dcnt <= dcnt + 2'd1;
      else                dcnt <= '0;
    end
  end

  // stage E: capture the returned product alongside the exact reference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_e      <= 1'b0;
      approx_e <= '0;
      exact_e  <= '0;
    end else begin
      v_e      <= (state == SWEEP);
      approx_e <= res_i;
      exact_e  <= {{DW{1'b0}}, muld_o} * {{DW{1'b0}}, mulr_o};
    end
  end

  ap_err_eval_acc #(
    .PW    (PWD),
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (load),
    .v_e     (v_e),
    .approx  (approx_e),
    .exact   (exact_e),
    .err_cnt (err_cnt),
    .sum_ed  (sum_ed),
    .max_ed  (max_ed)
  );

endmodule
